clk_gen_multi: RTL and testbench
================================

// Module: clk_gen_multi
// PURPOSE
//  Parametrised multi-channel clock/strobe generator for the controller; next generation of the single-channel divider.
//  N_CH independent channels, each with programmable period, high time, mode (off/auto/burst) and burst length.
//  Outputs are registered divided waveforms (no combinational clock gating), plus per-period tick strobes.
//  Config changes apply glitch-free at period boundaries. Sits between the host-command decoder and the DUT clock/step logic.
// PARAMETERS
//  N_CH      4   number of channels (>=1)
//  DIV_BITS  32  width of period and high-time fields
//  CNT_BITS  32  width of burst period count
// PORTS
//  clk         in   1                   system clock
//  rst_n       in   1                   asynchronous reset, active low
//  en          in   1                   global run enable; 0 freezes all channels
//  cfg_we      in   1                   config write strobe, one cycle
//  cfg_ch      in   max(1,clog2(N_CH))  target channel; values >= N_CH ignored
//  cfg_mode    in   2                   00 OFF, 01 AUTO, 10 BURST, 11 reserved (treated as OFF)
//  cfg_div     in   DIV_BITS            period P in clk cycles
//  cfg_high    in   DIV_BITS            high time H in clk cycles; 0 = 50%
//  cfg_count   in   CNT_BITS            BURST period count
//  clk_o       out  N_CH                divided waveform per channel, registered
//  tick_o      out  N_CH                1-cycle strobe on first high cycle of each period
//  busy_o      out  N_CH                channel running (AUTO, or BURST with periods left)
//  pending_o   out  N_CH                shadow config waiting for period boundary
//  done_o      out  N_CH                1-cycle strobe when a BURST completes
// BEHAVIOUR
//  Reset: all outputs 0, all channels OFF, phase 0, shadows empty. Async assert; synchronous deassert handled upstream.
//  Effective P = max(cfg_div,2). Effective H: cfg_high==0 -> floor(P/2); else clamp to 1..P-1. Compute in DIV_BITS, no overflow.
//  Per channel phase counter ph runs 0..P-1 then wraps to 0; wrap cycle (ph==P-1) is the period boundary.
//  clk_o is a flop: high exactly in cycles with ph<H while running; low in OFF/idle. tick_o high when ph==0 while running.
//  States per channel: OFF -> RUN_AUTO | RUN_BURST; RUN_BURST -> OFF after last period; any -> OFF on mode 00/11 write.
//  Write to non-running channel (OFF/idle): config loaded at the edge ending write cycle t; ph=0, clk_o/tick_o high in t+1.
//  Write to running channel: stored in shadow, pending_o=1; applied at the boundary, new period starts next cycle, pending_o falls.
//  Second write before apply overwrites shadow (last write wins). Write coincident with boundary cycle: applied at that boundary.
//  BURST: remaining count loaded from cfg_count, decremented at each boundary; at boundary with remaining==1 -> OFF,
//   busy_o falls and done_o pulses in the following cycle. cfg_count==0: channel stays OFF, no done_o, busy_o stays 0.
//  Writing BURST during BURST reloads count at boundary; no done_o for the interrupted burst.
//  OFF write while running: current period completes, then clk_o low; no done_o.
//  en=0: ph, counts, clk_o frozen (hold value); tick_o/done_o forced 0; config writes still accepted; boundaries not taken.
//  Reset mid-operation: immediate return to reset values, shadows discarded.
//  Channels independent; cfg_we affects only cfg_ch.
// STRUCTURE
//  Package clk_gen_pkg: mode_e enum (MODE_OFF, MODE_AUTO, MODE_BURST), MIN_DIV=2, cfg struct {mode,div,high,count}.
//  Sub-module clk_gen_channel: one channel (phase counter, burst counter, shadow, output flops).
//  Top: generate loop of N_CH clk_gen_channel, write decode of cfg_ch, output packing.
// TESTING
//  AUTO div=4 high=0 ch0 -> clk_o[0] pattern 1100 repeating from cycle after write; tick_o every 4 cycles.
//  AUTO div=5 high=7 -> H clamped to 4: 11110; div=1 -> treated as 2: 10 repeating.
//  BURST div=3 high=1 count=3 -> exactly 3 high cycles on clk_o, busy_o 9 cycles, done_o one cycle after, then low.
//  Running AUTO div=4; write div=6 mid-period -> pending_o=1, current 4-cycle period completes, then 6-cycle periods.
//  en=0 for 5 cycles mid-high -> clk_o held high, no ticks; en=1 resumes at same phase; period total = P+5.
//  Two channels: ch1 BURST while ch0 AUTO; cfg_ch=N_CH write ignored; async reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and constants for the multi-channel clock/strobe generator
// Contents: mode_e (host-visible channel mode), ch_state_e (channel run state),
//           MIN_DIV (smallest legal period), cfg_t (raw host config record),
//           decode_mode() (maps the 2-bit mode field, reserved code -> OFF).
package clk_gen_pkg;

  localparam int MIN_DIV      = 2;
  localparam int DEF_DIV_BITS = 32;
  localparam int DEF_CNT_BITS = 32;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_AUTO  = 2'b01,
    MODE_BURST = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_AUTO  = 2'b01,
    ST_BURST = 2'b10
  } ch_state_e;

  // Raw config record as written by the host at default field widths.
  typedef struct packed {
    mode_e                    mode;
    logic [DEF_DIV_BITS-1:0]  div;
    logic [DEF_DIV_BITS-1:0]  high;
    logic [DEF_CNT_BITS-1:0]  count;
  } cfg_t;

  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = MODE_AUTO;
      2'b10:   decode_mode = MODE_BURST;
      default: decode_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// rtl/clk_gen_channel.sv - one generator channel: phase/burst counters, shadow config, output flops
// Ports: clk, rst_n (async, active low), en (run/freeze),
//        cfg_we/cfg_mode/cfg_div/cfg_high/cfg_count (write for this channel),
//        clk_o (divided waveform), tick_o (period-start strobe), busy_o (running),
//        pending_o (shadow config waiting), done_o (burst-complete strobe).
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_BITS = 32,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_BITS-1:0] cfg_div,
  input  logic [DIV_BITS-1:0] cfg_high,
  input  logic [CNT_BITS-1:0] cfg_count,
  output logic                clk_o,
  output logic                tick_o,
  output logic                busy_o,
  output logic                pending_o,
  output logic                done_o
);

  // Config held in effective form: period and high time already clamped.
  typedef struct packed {
    mode_e               mode;
    logic [DIV_BITS-1:0] p;
    logic [DIV_BITS-1:0] h;
    logic [CNT_BITS-1:0] count;
  } eff_cfg_t;

  ch_state_e           state_q, state_d;
  logic [DIV_BITS-1:0] ph_q, ph_d;
  logic [DIV_BITS-1:0] p_q, p_d;
  logic [DIV_BITS-1:0] h_q, h_d;
  logic [CNT_BITS-1:0] rem_q, rem_d;
  logic                clk_q, clk_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  eff_cfg_t            shd_q, shd_d;
  logic                shd_vld_q, shd_vld_d;

  eff_cfg_t            in_cfg;
  eff_cfg_t            apply_cfg;
  logic                apply_req;
  logic                running;
  logic                boundary;
  logic                ld_go;
  ch_state_e           ld_state;

  // Clamp incoming fields; H stays in 1..P-1 so every period has a high and a low cycle.
  always_comb begin
    in_cfg.mode  = decode_mode(cfg_mode);
    in_cfg.p     = (cfg_div < DIV_BITS'(MIN_DIV)) ? DIV_BITS'(MIN_DIV) : cfg_div;
    in_cfg.count = cfg_count;
    if (cfg_high == '0) begin
      in_cfg.h = in_cfg.p >> 1;
    end else if (cfg_high >= in_cfg.p) begin
      in_cfg.h = in_cfg.p - DIV_BITS'(1);
    end else begin
      in_cfg.h = cfg_high;
    end
  end

  // A write in the same cycle as a load point wins over an older shadow.
  always_comb begin
    apply_cfg = cfg_we ? in_cfg : shd_q;
    apply_req = cfg_we | shd_vld_q;
    running   = (state_q != ST_OFF);
    boundary  = running && (ph_q == p_q - DIV_BITS'(1));
    ld_go     = (apply_cfg.mode == MODE_AUTO) ||
                ((apply_cfg.mode == MODE_BURST) && (apply_cfg.count != '0));
    if (!ld_go) begin
      ld_state = ST_OFF;
    end else if (apply_cfg.mode == MODE_AUTO) begin
      ld_state = ST_AUTO;
    end else begin
      ld_state = ST_BURST;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    p_d       = p_q;
    h_d       = h_q;
    rem_d     = rem_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    shd_d     = shd_q;
    shd_vld_d = shd_vld_q;

    if (cfg_we) begin
      shd_d     = in_cfg;
      shd_vld_d = 1'b1;
    end

    // With en low everything holds; the shadow still captures writes.
    if (en) begin
      if (!running || boundary) begin
        if (apply_req) begin
          state_d   = ld_state;
          p_d       = apply_cfg.p;
          h_d       = apply_cfg.h;
          rem_d     = apply_cfg.count;
          ph_d      = '0;
          clk_d     = ld_go;
          tick_d    = ld_go;
          shd_vld_d = 1'b0;
        end else if (running) begin
          ph_d = '0;
          if ((state_q == ST_BURST) && (rem_q == CNT_BITS'(1))) begin
            state_d = ST_OFF;
            clk_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
            if (state_q == ST_BURST) begin
              rem_d = rem_q - CNT_BITS'(1);
            end
          end
        end
      end else begin
        ph_d  = ph_q + DIV_BITS'(1);
        clk_d = (ph_d < h_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      ph_q      <= '0;
      p_q       <= DIV_BITS'(MIN_DIV);
      h_q       <= DIV_BITS'(1);
      rem_q     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      shd_q     <= '0;
      shd_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      p_q       <= p_d;
      h_q       <= h_d;
      rem_q     <= rem_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      shd_q     <= shd_d;
      shd_vld_q <= shd_vld_d;
    end
  end

  // Strobes are masked by en so a freeze suppresses them from its first cycle.
  assign clk_o     = clk_q;
  assign tick_o    = tick_q & en;
  assign done_o    = done_q & en;
  assign busy_o    = (state_q != ST_OFF);
  assign pending_o = shd_vld_q;

endmodule

// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - N_CH-channel clock/strobe generator top
// Ports: clk, rst_n (async, active low), en (global run enable),
//        cfg_we/cfg_ch/cfg_mode/cfg_div/cfg_high/cfg_count (config write; cfg_ch >= N_CH ignored),
//        clk_o/tick_o/busy_o/pending_o/done_o (one bit per channel).
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DIV_BITS = 32,
  parameter int CNT_BITS = 32,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_BITS-1:0] cfg_div,
  input  logic [DIV_BITS-1:0] cfg_high,
  input  logic [CNT_BITS-1:0] cfg_count,
  output logic [N_CH-1:0]     clk_o,
  output logic [N_CH-1:0]     tick_o,
  output logic [N_CH-1:0]     busy_o,
  output logic [N_CH-1:0]     pending_o,
  output logic [N_CH-1:0]     done_o
);

  logic [N_CH-1:0] ch_we;

  // Codes beyond the last channel match no index, so those writes fall away.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_gen_channel #(
      .DIV_BITS (DIV_BITS),
      .CNT_BITS (CNT_BITS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_we    (ch_we[g]),
      .cfg_mode  (cfg_mode),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_count (cfg_count),
      .clk_o     (clk_o[g]),
      .tick_o    (tick_o[g]),
      .busy_o    (busy_o[g]),
      .pending_o (pending_o[g]),
      .done_o    (done_o[g])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb/tb_clk_gen_multi.sv - scoreboard bench for clk_gen_multi (3 channels)
module tb_clk_gen_multi;

  localparam int NCH = 3;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            cfg_we;
  logic [1:0]      cfg_ch;
  logic [1:0]      cfg_mode;
  logic [31:0]     cfg_div;
  logic [31:0]     cfg_high;
  logic [31:0]     cfg_count;
  logic [NCH-1:0]  clk_o;
  logic [NCH-1:0]  tick_o;
  logic [NCH-1:0]  busy_o;
  logic [NCH-1:0]  pending_o;
  logic [NCH-1:0]  done_o;

  clk_gen_multi #(.N_CH(NCH), .DIV_BITS(32), .CNT_BITS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_count (cfg_count),
    .clk_o     (clk_o),
    .tick_o    (tick_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs {clk,tick,busy,pend,done} of one channel in one cycle.
  typedef struct {
    int         cy;
    int         ch;
    logic [4:0] e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    logic [4:0] got;
    while (sb.size() > 0 && sb[0].cy <= cyc) begin
      n_cmp++;
      if (sb[0].cy < cyc) begin
        n_err++;
        $display("FAIL stale_expect cyc=%0d ch=%0d expected for cycle %0d was never checked",
                 cyc, sb[0].ch, sb[0].cy);
      end else begin
        got = {clk_o[sb[0].ch], tick_o[sb[0].ch], busy_o[sb[0].ch],
               pending_o[sb[0].ch], done_o[sb[0].ch]};
        if (got !== sb[0].e) begin
          n_err++;
          $display("FAIL out_ch%0d cyc=%0d clk/tick/busy/pend/done got=%b required=%b",
                   sb[0].ch, cyc, got, sb[0].e);
        end
      end
      void'(sb.pop_front());
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int cy);
    while (cyc < cy) next();
  endtask

  task automatic wr(input int ch, input logic [1:0] m, input int d, input int h, input int c);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = m;
    cfg_div   = d;
    cfg_high  = h;
    cfg_count = c;
    next();
    cfg_we    = 1'b0;
  endtask

  task automatic push(input int cy, input int ch, input logic [4:0] e);
    exp_t x;
    x.cy = cy;
    x.ch = ch;
    x.e  = e;
    sb.push_back(x);
  endtask

  // Running channel: pat (MSB first, len bits) repeated, tick on the first bit of each repeat.
  task automatic exp_pat(input int ch, input int t0, input int len, input logic [7:0] pat,
                         input int reps, input logic pend);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < len; k++) begin
        push(t0 + r*len + k, ch, {pat[len-1-k], (k == 0), 1'b1, pend, 1'b0});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d bench did not finish, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n     = 1'b0;
    en        = 1'b1;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_div   = '0;
    cfg_high  = '0;
    cfg_count = '0;

    // Reset state on every channel.
    for (int c = 1; c <= 2; c++)
      for (int ch = 0; ch < NCH; ch++) push(c, ch, 5'b00000);
    next(); next(); next();
    rst_n = 1'b1;
    next();

    // AUTO div=4 high=0 -> 1100; then div=6 written mid-period goes to the shadow.
    t = cyc;
    wr(0, 2'b01, 4, 0, 0);
    exp_pat(0, t+1, 4, 8'b1100, 3, 1'b0);
    push(t+13, 0, 5'b11100);
    push(t+14, 0, 5'b10100);
    wait_until(t+14);
    wr(0, 2'b01, 6, 0, 0);
    push(t+15, 0, 5'b00110);
    push(t+16, 0, 5'b00110);
    push(t+17, 0, 5'b11100);
    wait_until(t+17);
    // OFF while running: the 6-cycle period completes, no done.
    wr(0, 2'b00, 0, 0, 0);
    push(t+18, 0, 5'b10110);
    push(t+19, 0, 5'b10110);
    push(t+20, 0, 5'b00110);
    push(t+21, 0, 5'b00110);
    push(t+22, 0, 5'b00110);
    push(t+23, 0, 5'b00000);
    push(t+24, 0, 5'b00000);
    wait_until(t+25);

    // div=5 high=7 -> H=4; div=1 written on the boundary cycle applies at once.
    t = cyc;
    wr(0, 2'b01, 5, 7, 0);
    exp_pat(0, t+1, 5, 8'b11110, 2, 1'b0);
    wait_until(t+10);
    wr(0, 2'b01, 1, 0, 0);
    exp_pat(0, t+11, 2, 8'b10, 3, 1'b0);
    wait_until(t+16);
    wr(0, 2'b00, 0, 0, 0);
    push(t+17, 0, 5'b00000);
    wait_until(t+18);

    // BURST div=3 high=1 count=3.
    t = cyc;
    wr(0, 2'b10, 3, 1, 3);
    exp_pat(0, t+1, 3, 8'b100, 3, 1'b0);
    push(t+10, 0, 5'b00001);
    push(t+11, 0, 5'b00000);
    push(t+12, 0, 5'b00000);
    wait_until(t+13);

    // Freeze for 5 cycles in the high phase of div=4 high=2.
    t = cyc;
    wr(0, 2'b01, 4, 2, 0);
    push(t+1, 0, 5'b11100);
    for (int k = 2; k <= 7; k++) push(t+k, 0, 5'b10100);
    push(t+8,  0, 5'b00100);
    push(t+9,  0, 5'b00100);
    push(t+10, 0, 5'b11100);
    push(t+11, 0, 5'b10100);
    push(t+12, 0, 5'b00100);
    push(t+13, 0, 5'b00100);
    push(t+14, 0, 5'b00000);
    next();
    en = 1'b0;
    repeat (5) next();
    en = 1'b1;
    wait_until(t+13);
    wr(0, 2'b00, 0, 0, 0);
    wait_until(t+15);

    // BURST with count 0 never starts.
    t = cyc;
    wr(2, 2'b10, 3, 0, 0);
    push(t+1, 2, 5'b00000);
    push(t+2, 2, 5'b00000);
    wait_until(t+3);

    // ch0 AUTO div=2, ch1 BURST div=4 high=3 count=2, write to ch3 ignored, reset mid-burst.
    t = cyc;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 5) push(t+k, 0, (k % 2 == 1) ? 5'b11100 : 5'b00100);
      else        push(t+k, 0, 5'b00000);
      case (k)
        1:       push(t+k, 1, 5'b00000);
        2:       push(t+k, 1, 5'b11100);
        3, 4:    push(t+k, 1, 5'b10100);
        5:       push(t+k, 1, 5'b00100);
        default: push(t+k, 1, 5'b00000);
      endcase
      push(t+k, 2, 5'b00000);
    end
    wr(0, 2'b01, 2, 0, 0);
    wr(1, 2'b10, 4, 3, 2);
    wr(3, 2'b01, 2, 0, 0);
    wait_until(t+6);
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
    next();

    for (int k = 0; k < 20 && sb.size() > 0; k++) next();
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain cyc=%0d left=%0d required=0", cyc, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
